// File: rtl/fetch_regs.sv
// fetch_regs: architectural register stage of the multicycle RISC-V core.
// Holds PC, OldPC, IR and the memory data register, and drives the shared
// memory address. A one-deep fetch wait state absorbs memory responses that
// arrive later than the fetch request.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   -> PC writes with result[1:0] != 0 are dropped and set the
//                sticky misaligned flag (cleared only by reset)
//   undefined -> PC loads result unconditionally, misaligned is tied 0
//
// Memory handshake: mem_req is high while an instruction fetch is
// outstanding (the request cycle in IDLE, and every WAIT cycle). mem_rvalid
// qualifies mem_rdata for exactly one cycle; there is no back-pressure, so a
// return is consumed in the cycle it is presented. A return seen while a
// fetch is in flight (or in the request cycle) loads IR; any other return
// loads the data register.
//
// The FSM has two states, so fetch_busy is a direct view of the state
// register (1 = WAIT) and doubles as its debug output.
module fetch_regs #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write,
    input  logic        ir_write,
    input  logic        adr_src,
    input  logic [31:0] result,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    output logic [31:0] pc,
    output logic [31:0] old_pc,
    output logic [31:0] instr,
    output logic [31:0] data,
    output logic        fetch_busy,
    output logic        misaligned
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] fetch_addr;
    logic        fetch_start;    // new fetch accepted this cycle (IDLE & ir_write)
    logic        capture_instr;  // memory return goes to IR this cycle
    logic        load_data;      // memory return goes to the data register
    logic        pc_load;        // PC takes result this cycle

    // Next-state and strobe decode; ir_write during WAIT is ignored.
    always_comb begin
        state_next    = state;
        fetch_start   = 1'b0;
        capture_instr = 1'b0;
        load_data     = 1'b0;
        case (state)
            S_IDLE: begin
                if (ir_write) begin
                    fetch_start = 1'b1;
                    if (mem_rvalid) begin
                        capture_instr = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                    end
                end else if (mem_rvalid) begin
                    load_data = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    capture_instr = 1'b1;
                    state_next    = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Memory address: held at the latched fetch address while waiting so a
    // concurrent PC update cannot disturb the outstanding request.
    always_comb begin
        mem_addr = adr_src ? result : pc;
        if (state == S_WAIT) begin
            mem_addr = fetch_addr;
        end
    end

    assign mem_req    = fetch_start || (state == S_WAIT);
    assign fetch_busy = (state == S_WAIT);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_q;

    assign pc_load    = pc_write && (result[1:0] == 2'b00);
    assign misaligned = misaligned_q;

    // Sticky misalign flag: set by any unaligned PC write, cleared by reset only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned_q <= 1'b0;
        end else if (pc_write && (result[1:0] != 2'b00)) begin
            misaligned_q <= 1'b1;
        end
    end
`else
    assign pc_load    = pc_write;
    assign misaligned = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Program counter; may be written in either state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (pc_load) begin
            pc <= result;
        end
    end

    // OldPC and fetch address both capture the pre-update PC when a fetch starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            old_pc     <= RESET_PC;
            fetch_addr <= RESET_PC;
        end else if (fetch_start) begin
            old_pc     <= pc;
            fetch_addr <= pc;
        end
    end

    // Instruction register: loads on the cycle the fetch data returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= RESET_INSTR;
        end else if (capture_instr) begin
            instr <= mem_rdata;
        end
    end

    // Memory data register: loads returns that are not instruction fetches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= 32'h0000_0000;
        end else if (load_data) begin
            data <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_regs.sv
// tb_fetch_regs: scoreboard bench for fetch_regs. The driver applies one
// input vector per cycle, pushes the outputs the reference model predicts
// for that cycle into exp_q, then advances the model at the clock edge.
// A separate monitor pops one entry per cycle and compares every output.
module tb_fetch_regs;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] RESET_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_write = 1'b0;
    logic        ir_write = 1'b0;
    logic        adr_src = 1'b0;
    logic [31:0] result = 32'h0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic [31:0] pc;
    logic [31:0] old_pc;
    logic [31:0] instr;
    logic [31:0] data;
    logic        fetch_busy;
    logic        misaligned;

    fetch_regs #(
        .RESET_PC   (RESET_PC),
        .RESET_INSTR(RESET_INSTR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc_write  (pc_write),
        .ir_write  (ir_write),
        .adr_src   (adr_src),
        .result    (result),
        .mem_rdata (mem_rdata),
        .mem_rvalid(mem_rvalid),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .pc        (pc),
        .old_pc    (old_pc),
        .instr     (instr),
        .data      (data),
        .fetch_busy(fetch_busy),
        .misaligned(misaligned)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] mem_addr;
        logic [31:0] pc;
        logic [31:0] old_pc;
        logic [31:0] instr;
        logic [31:0] data;
        logic        mem_req;
        logic        fetch_busy;
        logic        misaligned;
    } snap_t;

    localparam int W = $bits(snap_t);

    logic [W-1:0] exp_q[$];
    int cmp_count = 0;
    int err_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Architectural view: a fetch is either pending (address remembered) or
    // not; memory returns go to IR when a fetch is requested or pending.
    logic [31:0] m_pc, m_old_pc, m_instr, m_data, m_fetch_addr;
    logic        m_pending, m_mis;

    task automatic model_reset();
        m_pc         = RESET_PC;
        m_old_pc     = RESET_PC;
        m_instr      = RESET_INSTR;
        m_data       = 32'h0;
        m_fetch_addr = RESET_PC;
        m_pending    = 1'b0;
        m_mis        = 1'b0;
    endtask

    function automatic snap_t model_view();
        snap_t s;
        s.mem_addr   = m_pending ? m_fetch_addr : (adr_src ? result : m_pc);
        s.pc         = m_pc;
        s.old_pc     = m_old_pc;
        s.instr      = m_instr;
        s.data       = m_data;
        s.mem_req    = m_pending | ir_write;
        s.fetch_busy = m_pending;
        s.misaligned = m_mis;
        return s;
    endfunction

    task automatic model_step();
        if (!m_pending && ir_write) begin
            m_old_pc = m_pc;
            if (mem_rvalid) begin
                m_instr = mem_rdata;
            end else begin
                m_pending    = 1'b1;
                m_fetch_addr = m_pc;
            end
        end else if (m_pending && mem_rvalid) begin
            m_instr   = mem_rdata;
            m_pending = 1'b0;
        end else if (!m_pending && mem_rvalid) begin
            m_data = mem_rdata;
        end
        if (pc_write) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (result[1:0] != 2'b00) m_mis = 1'b1;
            else m_pc = result;
`else
            m_pc = result;
`endif
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic pw, input logic iw, input logic as,
                         input logic [31:0] res, input logic [31:0] rd, input logic rv);
        @(negedge clk);
        rst_n      = 1'b1;
        pc_write   = pw;
        ir_write   = iw;
        adr_src    = as;
        result     = res;
        mem_rdata  = rd;
        mem_rvalid = rv;
        exp_q.push_back(model_view());
        @(posedge clk);
        model_step();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        result     = 32'h0;
        mem_rdata  = 32'h0;
        mem_rvalid = 1'b0;
        rst_n      = 1'b0;
        model_reset();
        exp_q.push_back(model_view());
        @(posedge clk);
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        snap_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mem_addr", mem_addr, e.mem_addr);
                check("mem_req", {31'b0, mem_req}, {31'b0, e.mem_req});
                check("pc", pc, e.pc);
                check("old_pc", old_pc, e.old_pc);
                check("instr", instr, e.instr);
                check("data", data, e.data);
                check("fetch_busy", {31'b0, fetch_busy}, {31'b0, e.fetch_busy});
                check("misaligned", {31'b0, misaligned}, {31'b0, e.misaligned});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        logic [31:0] r;
        model_reset();

        // Reset state.
        apply_reset();
        idle_cycle();

        // Zero-wait fetch with concurrent PC update.
        drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0050_0093, 1'b1);
        idle_cycle();

        // Move PC to 8, then a fetch answered three cycles later.
        drive(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'hC, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 1'b0);   // ignored ir_write, adr_src
        drive(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0);   // PC write during WAIT
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h00A0_0113, 1'b1);
        idle_cycle();

        // Load from a data address.
        drive(1'b0, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1);
        idle_cycle();

        // Unaligned PC write.
        drive(1'b1, 1'b0, 1'b0, 32'h102, 32'h0, 1'b0);
        idle_cycle();
        idle_cycle();

        // Reset during WAIT, then a stray return.
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        idle_cycle();
        apply_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 1'b1);
        idle_cycle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                apply_reset();
            end else begin
                r = $urandom;
                if ($urandom_range(0, 7) != 0) r[1:0] = 2'b00;
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), r, $urandom,
                      1'($urandom_range(0, 2) == 0));
            end
        end

        idle_cycle();
        @(negedge clk);
        #4;
        cmp_count++;
        if (exp_q.size() != 0) begin
            err_count++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule

// File: doc/fetch_regs.md
# fetch_regs

Architectural register stage for the multicycle RISC-V core: holds PC, OldPC, the instruction register and the memory data register, and drives the shared memory address. It sits directly upstream of the control unit, producing `instr` from the `ir_write`/`pc_write`/`adr_src` strobes the control unit emits. It also absorbs variable-latency memory responses through a one-deep fetch wait state, reporting `fetch_busy`.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset
- `RESET_INSTR`, 32'h0000_0013, IR value after reset (ADDI x0,x0,0)

- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `pc_write` in 1: load PC from `result` this cycle
- `ir_write` in 1: start instruction fetch at current PC
- `adr_src` in 1: 0 selects PC as memory address, 1 selects `result`
- `result` in 32: result-mux value (next PC / data address)
- `mem_rdata` in 32: memory read data
- `mem_rvalid` in 1: `mem_rdata` valid this cycle
- `mem_addr` out 32: memory address
- `mem_req` out 1: instruction fetch request outstanding
- `pc` out 32: current PC
- `old_pc` out 32: PC of the instruction in IR
- `instr` out 32: instruction register
- `data` out 32: memory data register
- `fetch_busy` out 1: fetch pending, IR not yet valid
- `misaligned` out 1: sticky PC-misalign flag (see Configuration)

## Operation
- States: IDLE, WAIT.
- `mem_addr`: in WAIT = latched `fetch_addr`; otherwise `adr_src ? result : pc`.
- `mem_req` = (IDLE & `ir_write`) | WAIT.
- IDLE & `ir_write` & `mem_rvalid`: `instr`<=`mem_rdata`, `old_pc`<=`pc` (pre-update value), stay IDLE.
- IDLE & `ir_write` & !`mem_rvalid`: `old_pc`<=`pc`, `fetch_addr`<=`pc`, go WAIT.
- WAIT & `mem_rvalid`: `instr`<=`mem_rdata`, go IDLE. WAIT & !`mem_rvalid`: hold.
- `ir_write` in WAIT: ignored, no second request.
- IDLE & !`ir_write` & `mem_rvalid`: `data`<=`mem_rdata`. `data` never loads on a cycle that captures `instr`.
- `pc_write`: `pc`<=`result` in any state. A PC update during WAIT does not change `fetch_addr` or `mem_addr`.
- `ir_write` and `pc_write` in the same cycle (normal FETCH): `old_pc` takes old PC, `pc` takes `result`, and the fetch address is the old PC.
- `fetch_busy` = (state==WAIT).

## Timing
- Reset, asynchronous: `pc`=RESET_PC, `old_pc`=RESET_PC, `instr`=RESET_INSTR, `data`=0, `fetch_addr`=RESET_PC, state=IDLE, `misaligned`=0, so `fetch_busy`=0 and `mem_req`=0 when `ir_write`=0.
- Reset in WAIT: returns to IDLE; a late `mem_rvalid` after reset is treated as a data return.
- All register outputs update on the rising `clk` edge following the strobe.
- `mem_addr` and `mem_req` are combinational from state, strobes and `result`.
- Zero-wait memory (`rvalid` with request): `instr` is valid 1 cycle after `ir_write`.
- N-cycle response: `instr` is valid the cycle after `rvalid`, and `fetch_busy` is high for N cycles.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - `pc_write` with `result[1:0]`!=0 leaves `pc` unchanged and sets `misaligned`.
  - `misaligned` stays set until reset.
  - Aligned writes behave normally.
- Not defined:
  - `pc` loads `result` unconditionally.
  - `misaligned` is tied 0.

## Test plan
- Reset release -> `pc`=0, `instr`=0x00000013, `data`=0, `fetch_busy`=0, `mem_addr`=0.
- Zero-wait fetch: `ir_write`=`pc_write`=1, `result`=4, `mem_rvalid`=1, `mem_rdata`=0x00500093 -> next cycle `instr`=0x00500093, `old_pc`=0, `pc`=4.
- 3-cycle fetch: `ir_write` at `pc`=8 with `pc_write`, `result`=0xC, `rvalid` 3 cycles later -> `fetch_busy` high 3 cycles, `mem_addr`=8 throughout WAIT, `instr` captured, `pc`=0xC, `old_pc`=8.
- Load: `adr_src`=1, `result`=0x100, `mem_rvalid`=1, `mem_rdata`=0xDEADBEEF, `ir_write`=0 -> `mem_addr`=0x100, `data`=0xDEADBEEF, `instr` unchanged.
- `rst_n` low during WAIT -> state IDLE, `pc`=RESET_PC, `fetch_busy`=0, and a subsequent stray `rvalid` loads `data` only.
- Macro on: `pc_write`, `result`=0x102 -> `pc` unchanged, `misaligned`=1 until reset. Macro off: `pc`=0x102, `misaligned`=0.
